systolic_ctrl: RTL and testbench

Sequencer for the 8x8 systolic MVM/MMM datapath. Per tile it issues weight/data SRAM reads, drives `alu_start` and `cycle_num` into the array, then drains the array one row at a time via `matrix_index` with a valid/ready handshake. A job is a run of back-to-back tiles started by a single start pulse from the host/top-level FSM.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_ctrl_if.sv | 45 ++++
 rtl/systolic_addr_gen.sv | 55 +++++
 rtl/systolic_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encoding,
// default array geometry and the per-tile compute length derivation.
package systolic_pkg;

    localparam int ARRAY_SIZE_DEF    = 8;
    localparam int K_ACCUM_DEPTH_DEF = 8;

    // Compute cycles needed for one tile: fill + accumulate + flush of the array.
    function automatic int calc_run_cycles(input int array_size, input int k_depth);
        return array_size + 2 * k_depth + 1;
    endfunction

    localparam int RUN_CYCLES_DEF = calc_run_cycles(ARRAY_SIZE_DEF, K_ACCUM_DEPTH_DEF);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host/array-facing signal bundle of the systolic sequencer.
// The master side is the sequencer; the slave side is the host plus array.
// Optional macro SYSTOLIC_CTRL_PERF_EN adds the stall_cycles counter output.
interface systolic_ctrl_if #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TILE_CNT_WIDTH = 8
);
    logic                      start;
    logic                      abort;
    logic [TILE_CNT_WIDTH-1:0] tile_count;
    logic [ADDR_WIDTH-1:0]     base_addr_w;
    logic [ADDR_WIDTH-1:0]     base_addr_d;
    logic                      sram_ren;
    logic [ADDR_WIDTH-1:0]     sram_raddr_w;
    logic [ADDR_WIDTH-1:0]     sram_raddr_d;
    logic                      alu_start;
    logic [8:0]                cycle_num;
    logic [5:0]                matrix_index;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      done;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0]               stall_cycles;
`endif

    modport master (
        input  start, abort, tile_count, base_addr_w, base_addr_d, out_ready,
        output sram_ren, sram_raddr_w, sram_raddr_d, alu_start, cycle_num,
               matrix_index, out_valid, busy, done
`ifdef SYSTOLIC_CTRL_PERF_EN
               , stall_cycles
`endif
    );

    modport slave (
        output start, abort, tile_count, base_addr_w, base_addr_d, out_ready,
        input  sram_ren, sram_raddr_w, sram_raddr_d, alu_start, cycle_num,
               matrix_index, out_valid, busy, done
`ifdef SYSTOLIC_CTRL_PERF_EN
               , stall_cycles
`endif
    );

endinterface

// File: rtl/systolic_addr_gen.sv
// SRAM read address generator: latches a job base, steps one word per read
// and jumps to the next tile base (base + STRIDE) between tiles.
// The address wraps modulo 2^ADDR_WIDTH.
module systolic_addr_gen
    import systolic_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int STRIDE     = RUN_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_V = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ONE_V    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] tile_base_q, tile_base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Next address selection; clear beats load beats tile advance beats step.
    always_comb begin
        tile_base_d = tile_base_q;
        addr_d      = addr_q;
        if (clear_i) begin
            addr_d = '0;
        end else if (load_i) begin
            tile_base_d = base_i;
            addr_d      = base_i;
        end else if (advance_i) begin
            tile_base_d = tile_base_q + STRIDE_V;
            addr_d      = tile_base_q + STRIDE_V;
        end else if (step_i) begin
            addr_d = addr_q + ONE_V;
        end
    end

    // Address and tile base registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_base_q <= '0;
            addr_q      <= '0;
        end else begin
            tile_base_q <= tile_base_d;
            addr_q      <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic MVM/MMM array: prefetch, compute and
// row-by-row drain for each tile of a job, with abort and done signalling.
// Optional macro SYSTOLIC_CTRL_PERF_EN adds a saturating drain-stall counter.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE     = ARRAY_SIZE_DEF,
    parameter int K_ACCUM_DEPTH  = K_ACCUM_DEPTH_DEF,
    parameter int ADDR_WIDTH     = 10,
    parameter int TILE_CNT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    systolic_ctrl_if.master bus
);
    localparam int RUN_CYCLES = calc_run_cycles(ARRAY_SIZE, K_ACCUM_DEPTH);
    localparam logic [8:0] CYC_LAST      = 9'(RUN_CYCLES - 1);
    // Reads stop one cycle before the end of RUN (the prefetch supplied the first one).
    localparam logic [8:0] CYC_LAST_READ = 9'(RUN_CYCLES - 2);
    localparam logic [5:0] IDX_LAST      = 6'(ARRAY_SIZE - 1);
    localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE = TILE_CNT_WIDTH'(1);

    state_e                    state_q;
    logic [8:0]                cycle_q;
    logic [5:0]                idx_q;
    logic [TILE_CNT_WIDTH-1:0] tiles_left_q;
    logic                      ren_q;
    logic                      alu_q;
    logic                      valid_q;
    logic                      busy_q;
    logic                      done_q;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0]               stall_q;
`endif

    logic accept_job;
    logic last_row;
    logic more_tiles;
    logic addr_step;
    logic addr_adv;
    logic addr_clr;

    // out_valid is high for the whole of DRAIN, so ready alone completes a row.
    assign last_row   = (state_q == DRAIN) && bus.out_ready && (idx_q == IDX_LAST);
    assign more_tiles = (tiles_left_q != TILE_ONE);
    assign accept_job = (state_q == IDLE) && bus.start && !bus.abort && (bus.tile_count != '0);
    assign addr_step  = !bus.abort && ((state_q == PREFETCH) ||
                                       ((state_q == RUN) && (cycle_q < CYC_LAST_READ)));
    assign addr_adv   = !bus.abort && last_row && more_tiles;
    assign addr_clr   = bus.abort || (last_row && !more_tiles);

    logic [ADDR_WIDTH-1:0] base_sel [2];
    logic [ADDR_WIDTH-1:0] addr_out [2];

    assign base_sel[0] = bus.base_addr_w;
    assign base_sel[1] = bus.base_addr_d;

    // Index 0 drives the weight SRAM, index 1 the data SRAM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addr
            systolic_addr_gen #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .STRIDE     (RUN_CYCLES)
            ) u_addr_gen (
                .clk       (clk),
                .rst       (rst),
                .clear_i   (addr_clr),
                .load_i    (accept_job),
                .advance_i (addr_adv),
                .step_i    (addr_step),
                .base_i    (base_sel[gi]),
                .addr_o    (addr_out[gi])
            );
        end
    endgenerate

    // Job sequencer: state, counters and all registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            idx_q        <= '0;
            tiles_left_q <= '0;
            ren_q        <= 1'b0;
            alu_q        <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SYSTOLIC_CTRL_PERF_EN
            stall_q      <= '0;
`endif
        end else if (bus.abort) begin
            state_q <= IDLE;
            cycle_q <= '0;
            idx_q   <= '0;
            ren_q   <= 1'b0;
            alu_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
`ifdef SYSTOLIC_CTRL_PERF_EN
                        stall_q <= '0;
`endif
                        if (bus.tile_count != '0) begin
                            tiles_left_q <= bus.tile_count;
                            ren_q        <= 1'b1;
                            state_q      <= PREFETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                PREFETCH: begin
                    state_q <= RUN;
                    alu_q   <= 1'b1;
                    cycle_q <= '0;
                    ren_q   <= 1'b1;
                end
                RUN: begin
                    if (cycle_q == CYC_LAST) begin
                        state_q <= DRAIN;
                        alu_q   <= 1'b0;
                        cycle_q <= '0;
                        ren_q   <= 1'b0;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        cycle_q <= cycle_q + 9'd1;
                        ren_q   <= (cycle_q < CYC_LAST_READ);
                    end
                end
                DRAIN: begin
`ifdef SYSTOLIC_CTRL_PERF_EN
                    if (!bus.out_ready && (stall_q != 16'hFFFF)) begin
                        stall_q <= stall_q + 16'd1;
                    end
`endif
                    if (bus.out_ready) begin
                        if (idx_q == IDX_LAST) begin
                            valid_q <= 1'b0;
                            idx_q   <= '0;
                            if (more_tiles) begin
                                tiles_left_q <= tiles_left_q - TILE_ONE;
                                ren_q        <= 1'b1;
                                state_q      <= PREFETCH;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_ren     = ren_q;
    assign bus.sram_raddr_w = addr_out[0];
    assign bus.sram_raddr_d = addr_out[1];
    assign bus.alu_start    = alu_q;
    assign bus.cycle_num    = cycle_q;
    assign bus.matrix_index = idx_q;
    assign bus.out_valid    = valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
`ifdef SYSTOLIC_CTRL_PERF_EN
    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed scoreboard bench for systolic_ctrl: expected reads, cycle numbers
// and drain rows are queued when a job is started and consumed by a monitor.
module tb_systolic_ctrl;

    localparam int RC = 25;   // compute cycles per tile for an 8x8 array, depth 8
    localparam int AS = 8;    // drain rows per tile

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_ctrl_if #(.ADDR_WIDTH(10), .TILE_CNT_WIDTH(8)) bus ();

    systolic_ctrl #(
        .ARRAY_SIZE     (8),
        .K_ACCUM_DEPTH  (8),
        .ADDR_WIDTH     (10),
        .TILE_CNT_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] rd_q  [$];
    int          cyc_q [$];
    int          row_q [$];

    int done_seen = 0;
    int done_cyc  = 0;
    int start_cyc = 0;
    int d0        = 0;
    int job_no    = 0;

    logic [19:0] mon_e;
    int          mon_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ren"},   32'(bus.sram_ren),     32'd0);
        check({tag, "_addrw"}, 32'(bus.sram_raddr_w), 32'd0);
        check({tag, "_addrd"}, 32'(bus.sram_raddr_d), 32'd0);
        check({tag, "_alu"},   32'(bus.alu_start),    32'd0);
        check({tag, "_cyc"},   32'(bus.cycle_num),    32'd0);
        check({tag, "_idx"},   32'(bus.matrix_index), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid),    32'd0);
        check({tag, "_busy"},  32'(bus.busy),         32'd0);
        check({tag, "_done"},  32'(bus.done),         32'd0);
    endtask

    // Monitor: consumes expectations as the DUT issues reads, compute cycles and rows.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.sram_ren) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(bus.sram_ren), 32'd0);
                end else begin
                    mon_e = rd_q.pop_front();
                    check("rd_addr_w", 32'(bus.sram_raddr_w), 32'(mon_e[19:10]));
                    check("rd_addr_d", 32'(bus.sram_raddr_d), 32'(mon_e[9:0]));
                end
            end
            if (bus.alu_start) begin
                if (cyc_q.size() == 0) begin
                    check("alu_unexpected", 32'(bus.alu_start), 32'd0);
                end else begin
                    mon_v = cyc_q.pop_front();
                    check("cycle_num", 32'(bus.cycle_num), mon_v);
                end
            end else begin
                check("cycle_num_idle", 32'(bus.cycle_num), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (row_q.size() == 0) begin
                    check("row_unexpected", 32'(bus.out_valid), 32'd0);
                end else begin
                    mon_v = row_q.pop_front();
                    check("matrix_index", 32'(bus.matrix_index), mon_v);
                end
            end
            if (bus.done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_job(input int tiles, input int bw, input int bd);
        logic [9:0] aw, ad;
        for (int t = 0; t < tiles; t++) begin
            for (int r = 0; r < RC; r++) begin
                aw = 10'(bw + t * RC + r);
                ad = 10'(bd + t * RC + r);
                rd_q.push_back({aw, ad});
                cyc_q.push_back(r);
            end
            for (int i = 0; i < AS; i++) row_q.push_back(i);
        end
    endtask

    task automatic flush_queues();
        rd_q.delete();
        cyc_q.delete();
        row_q.delete();
    endtask

    task automatic start_job(input int tiles, input int bw, input int bd);
        job_no++;
        push_job(tiles, bw, bd);
        bus.tile_count  = 8'(tiles);
        bus.base_addr_w = 10'(bw);
        bus.base_addr_d = 10'(bd);
        bus.start       = 1'b1;
        start_cyc       = cyc;
        d0              = done_seen;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("start_busy", 32'(bus.busy), 32'd1);
        $display("job %0d: start tiles=%0d base_w=%03h base_d=%03h cycle=%0d",
                 job_no, tiles, bw, bd, start_cyc);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        for (int i = 0; i < 2000 && done_seen == d0; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_latency"},    32'(done_cyc - start_cyc), 32'(exp_lat));
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_rd_left"},    32'(rd_q.size()), 32'd0);
        check({tag, "_cyc_left"},   32'(cyc_q.size()), 32'd0);
        check({tag, "_row_left"},   32'(row_q.size()), 32'd0);
        $display("job %0d: %s done latency=%0d", job_no, tag, done_cyc - start_cyc);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.tile_count  = '0;
        bus.base_addr_w = '0;
        bus.base_addr_d = '0;
        bus.out_ready   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single tile
        start_job(1, 0, 'h100);
        check("t1_prefetch_ren", 32'(bus.sram_ren), 32'd1);
        check("t1_prefetch_alu", 32'(bus.alu_start), 32'd0);
        wait_done("single", 35);

        // Backpressure at row 4
        start_job(1, 'h10, 'h120);
        for (int i = 0; i < 200 && !(bus.out_valid && bus.matrix_index == 6'd4); i++) begin
            @(posedge clk); #1;
        end
        check("bp_reach_idx4", 32'(bus.matrix_index), 32'd4);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_idx", 32'(bus.matrix_index), 32'd4);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        wait_done("backpressure", 38);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("stall_cycles", 32'(bus.stall_cycles), 32'd3);
`endif

        // Three tiles with a stray start mid-job
        start_job(3, 0, 'h200);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("stall_cleared", 32'(bus.stall_cycles), 32'd0);
`endif
        repeat (5) begin @(posedge clk); #1; end
        bus.tile_count = 8'd5;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("three_tiles", 103);

        // Zero tiles
        start_job(0, 'h55, 'h66);
        wait_done("zero_tiles", 1);

        // Abort at cycle_num 10, then a normal job
        start_job(1, 0, 'h100);
        for (int i = 0; i < 200 && !(bus.alu_start && bus.cycle_num == 9'd10); i++) begin
            @(posedge clk); #1;
        end
        check("ab_reach_cyc10", 32'(bus.cycle_num), 32'd10);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_idle("abort10");
        check("abort10_rd_left", 32'(rd_q.size()), 32'd13);
        check("abort10_cyc_left", 32'(cyc_q.size()), 32'd14);
        check("abort10_row_left", 32'(row_q.size()), 32'd8);
        flush_queues();
        repeat (3) begin @(posedge clk); #1; end
        check("abort10_no_done", 32'(done_seen - d0), 32'd0);
        $display("job %0d: aborted at cycle_num 10", job_no);
        start_job(1, 'h20, 'h300);
        wait_done("after_abort", 35);

        // Abort on the final drain handshake
        start_job(1, 'h40, 'h80);
        for (int i = 0; i < 200 && !(bus.out_valid && bus.matrix_index == 6'd7); i++) begin
            @(posedge clk); #1;
        end
        check("abl_reach_idx7", 32'(bus.matrix_index), 32'd7);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_idle("abort_last");
        flush_queues();
        repeat (3) begin @(posedge clk); #1; end
        check("abort_last_no_done", 32'(done_seen - d0), 32'd0);
        $display("job %0d: aborted on last drain row", job_no);

        // Start and abort together in IDLE
        d0 = done_seen;
        bus.tile_count = 8'd1;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_busy", 32'(bus.busy), 32'd0);
        check("sa_ren", 32'(bus.sram_ren), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("sa_no_done", 32'(done_seen - d0), 32'd0);
        check("sa_still_idle", 32'(bus.busy), 32'd0);
        $display("start with abort in IDLE: ignored");

        // Address wrap on the data side
        start_job(1, 'h3F8, 'h3F0);
        wait_done("wrap", 35);

        // Asynchronous reset in the middle of DRAIN
        start_job(1, 'h10, 'h20);
        for (int i = 0; i < 200 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("rst_reach_drain", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_mid_drain");
        flush_queues();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_no_done", 32'(done_seen - d0), 32'd0);
        check("rst_idle_busy", 32'(bus.busy), 32'd0);
        $display("job %0d: reset during drain", job_no);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
